// File: rtl/pipeline_ctrl_pkg.sv
// Shared encodings and constants for the pipeline run-control sequencer.
// Consumed by pipeline_sequencer and load_use_detector.
package pipeline_ctrl_pkg;

  localparam int STATE_W          = 3;
  localparam int DRAIN_CYCLES_DEF = 3;

  function automatic int clogb2(input int value);
    int r;
    int v;
    r = 0;
    v = value;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam int REG_ADDR_W = clogb2(32 - 1);

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

endpackage

// File: rtl/pipeline_sequencer_lud.sv
// Load-use hazard compare: an ID/EX load whose rt feeds the IF/ID instruction.
// Only instantiated when PIPELINE_HAZARD_STALL_EN is defined.
module load_use_detector
  import pipeline_ctrl_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic          enable_i,
  input  logic          mem_read_i,
  input  logic [AW-1:0] ex_rt_i,
  input  logic [AW-1:0] id_rs_i,
  input  logic [AW-1:0] id_rt_i,
  output logic          hazard_o
);

  logic match;

  assign match    = (ex_rt_i == id_rs_i) | (ex_rt_i == id_rt_i);
  assign hazard_o = enable_i & mem_read_i & (|ex_rt_i) & match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run-control sequencer: continuous/step enable, HALT drain, cycle counter.
// Optional load-use stall under PIPELINE_HAZARD_STALL_EN.
module pipeline_sequencer
  import pipeline_ctrl_pkg::*;
#(
  parameter int CANT_REGISTROS   = 32,
  parameter int DRAIN_CYCLES     = DRAIN_CYCLES_DEF,
  parameter int CANT_BITS_CICLOS = 32
) (
  input  logic                                  i_clock,
  input  logic                                  i_soft_reset,
  input  logic                                  i_start_continuous,
  input  logic                                  i_start_step,
  input  logic                                  i_step,
  input  logic                                  i_abort,
  input  logic                                  i_halt_detected,
  input  logic                                  i_id_ex_mem_read,
  input  logic [clogb2(CANT_REGISTROS-1)-1:0]   i_id_ex_reg_rt,
  input  logic [clogb2(CANT_REGISTROS-1)-1:0]   i_if_id_reg_rs,
  input  logic [clogb2(CANT_REGISTROS-1)-1:0]   i_if_id_reg_rt,
  output logic                                  o_enable_pipeline,
  output logic                                  o_enable_pc,
  output logic                                  o_enable_if_id,
  output logic                                  o_bubble,
  output logic                                  o_done,
  output logic [STATE_W-1:0]                    o_state,
  output logic [CANT_BITS_CICLOS-1:0]           o_cycle_count
);

  localparam int AW = clogb2(CANT_REGISTROS - 1);
  localparam int DW = (DRAIN_CYCLES < 2) ? 1
                    : $clog2(DRAIN_CYCLES + 1);
  localparam logic [DW-1:0] DRN_LOAD = DW'(DRAIN_CYCLES);
  localparam state_t HALT_NEXT =
    (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;

  state_t                      state_q, state_d;
  logic [DW-1:0]               drn_q, drn_d;
  logic [CANT_BITS_CICLOS-1:0] cyc_q, cyc_d;
  logic                        en_q, en_d;
  logic                        done_q, done_d;
  logic                        clr;

  always_comb begin
    state_d = state_q;
    drn_d   = drn_q;
    clr     = 1'b0;
    if (i_abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start_continuous) begin
            state_d = ST_RUN;
            clr     = 1'b1;
          end else if (i_start_step) begin
            state_d = ST_STEP_WAIT;
            clr     = 1'b1;
          end
        end
        ST_RUN: begin
          if (en_q && i_halt_detected) begin
            state_d = HALT_NEXT;
            drn_d   = DRN_LOAD;
          end
        end
        ST_STEP_WAIT: begin
          if (i_step) state_d = ST_STEP_EXEC;
        end
        ST_STEP_EXEC: begin
          if (i_halt_detected) begin
            state_d = HALT_NEXT;
            drn_d   = DRN_LOAD;
          end else begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_DRAIN: begin
          drn_d = drn_q - DW'(1);
          if (drn_q <= DW'(1)) state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end

    en_d   = (state_d == ST_RUN) || (state_d == ST_STEP_EXEC) ||
             (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);

    cyc_d = cyc_q;
    if (clr) begin
      cyc_d = '0;
    end else if (en_q && (cyc_q != '1)) begin
      cyc_d = cyc_q + CANT_BITS_CICLOS'(1);
    end
  end

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state_q <= ST_IDLE;
      drn_q   <= '0;
      cyc_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drn_q   <= drn_d;
      cyc_q   <= cyc_d;
      en_q    <= en_d;
      done_q  <= done_d;
    end
  end

  assign o_enable_pipeline = en_q;
  assign o_done            = done_q;
  assign o_state           = state_q;
  assign o_cycle_count     = cyc_q;

`ifdef PIPELINE_HAZARD_STALL_EN
  logic hazard;

  load_use_detector #(
    .AW (AW)
  ) u_lud (
    .enable_i   (en_q),
    .mem_read_i (i_id_ex_mem_read),
    .ex_rt_i    (i_id_ex_reg_rt),
    .id_rs_i    (i_if_id_reg_rs),
    .id_rt_i    (i_if_id_reg_rt),
    .hazard_o   (hazard)
  );

  assign o_enable_pc    = en_q & ~hazard;
  assign o_enable_if_id = en_q & ~hazard;
  assign o_bubble       = hazard;
`else
  logic unused_hz;
  assign unused_hz = ^{i_id_ex_mem_read, i_id_ex_reg_rt,
                       i_if_id_reg_rs, i_if_id_reg_rt};

  assign o_enable_pc    = en_q;
  assign o_enable_if_id = en_q;
  assign o_bubble       = 1'b0;
`endif

endmodule
